// File: rtl/cpu_defs.sv
// Shared CPU definitions: bridge FSM states, request source tags, AXI ids and access sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } bridge_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } bridge_src_t;

    localparam logic [3:0] AXI_ID_INST    = 4'd0;
    localparam logic [3:0] AXI_ID_DATA    = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/bridge_wstrb_gen.sv
// Byte-lane strobe generator from access size and low address bits.
// Latency: combinational.
// Backpressure: none.
module bridge_wstrb_gen
    import cpu_defs::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SZ_BYTE: wstrb = 4'b0001 << addr_lo;
            SZ_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Two sram-like channels (inst, data) onto one AXI3 master, one transaction in flight, data wins ties.
// Latency: read >= 3 cycles grant->data_ok; write data_ok on bvalid (on AW/W completion with BRIDGE_WRITE_EARLY_ACK_EN).
// Backpressure: addr_ok held low while busy; waits on arready/rvalid/awready/wready/bvalid indefinitely.
module sram_axi_bridge
    import cpu_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,

    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    bridge_state_t     state;
    bridge_src_t       src_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done;
    logic              w_done;

    logic              grant_data;
    logic              grant_inst;
    logic              sel_wr;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              aw_hs;
    logic              w_hs;
    logic              wr_fin;
    logic              rd_ok;
    logic              wr_ok;
    logic              resp_ok;
    logic              unused_axi;

    assign grant_data = (state == IDLE) && data_req;
    assign grant_inst = (state == IDLE) && !data_req && inst_req;

    assign sel_wr    = data_req ? data_wr    : inst_wr;
    assign sel_size  = data_req ? data_size  : inst_size;
    assign sel_addr  = data_req ? data_addr  : inst_addr;
    assign sel_wdata = data_req ? data_wdata : inst_wdata;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign wr_fin = (state == WR_REQ) && (aw_done || aw_hs) && (w_done || w_hs);
    assign rd_ok  = (state == RD_DATA) && rvalid;

`ifdef BRIDGE_WRITE_EARLY_ACK_EN
    assign wr_ok = wr_fin;
`else
    assign wr_ok = (state == WR_RESP) && bvalid;
`endif

    // Outputs are gated by resetn so nothing handshakes during the reset cycle.
    assign resp_ok      = resetn && ((rd_ok && !wr_q) || (wr_ok && wr_q));
    assign inst_addr_ok = resetn && grant_inst;
    assign data_addr_ok = resetn && grant_data;
    assign inst_data_ok = resp_ok && (src_q == INST);
    assign data_data_ok = resp_ok && (src_q == DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = (src_q == DATA) ? AXI_ID_DATA : AXI_ID_INST;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = AXI_ID_DATA;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid   = AXI_ID_DATA;
    assign wdata = wdata_q;
    assign wlast = 1'b1;

    assign unused_axi = ^{rid, rresp, rlast, bid, bresp};

    bridge_wstrb_gen u_wstrb (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wstrb   (wstrb)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            src_q   <= INST;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        src_q   <= grant_data ? DATA : INST;
                        wr_q    <= sel_wr;
                        size_q  <= sel_size;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (sel_wr) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Later assignments override the flag sets above.
                    if (wr_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data memory ports, inside the top-level CPU wrapper.
- Converts two sram-like request channels (req/addr_ok/data_ok) into a single AXI3 master port.
- Supports one outstanding transaction at a time.
- When both channels request in the same cycle, the data channel wins arbitration.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- resetn  in  1  synchronous active-low reset.
- inst_req, inst_wr  in  1 each  instruction-channel request valid and write flag.
- inst_size  in  2  access size: 0=byte, 1=half, 2=word.
- inst_addr, inst_wdata  in  32 each  request address and write data.
- inst_rdata  out  32  read data.
- inst_addr_ok, inst_data_ok  out  1 each  request-accept pulse and response pulse.
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: same as the inst_* ports, for the data channel.
- AXI AR: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 out; arready 1 in.
- AXI R: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 in; rready 1 out.
- AXI AW: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1 out; awready 1 in.
- AXI W: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1 out; wready 1 in.
- AXI B: bid 4, bresp 2, bvalid 1 in; bready 1 out.

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset value is IDLE.
- Reset values: all valid and ready outputs, addr_ok and data_ok are 0; all latched request fields are 0.
- Arbitration (IDLE only): grant = data_req ? DATA : inst_req ? INST : none.
  - addr_ok for the granted channel is combinational: asserted in the same cycle as IDLE && req.
  - The non-granted channel's addr_ok stays 0.
- On grant, latch source, wr, size, addr and wdata.
  - Next state is RD_ADDR if wr=0, WR_REQ if wr=1.
  - No new grant is made until the FSM returns to IDLE.
- RD_ADDR: arvalid=1, araddr and arsize taken from the latch.
  - arid = 0 for INST, 1 for DATA.
  - On arready, go to RD_DATA.
- RD_DATA: rready=1.
  - On rvalid, the source's data_ok is asserted combinationally for exactly that cycle; rdata passes straight through to the source's *_rdata.
  - Go to IDLE. rresp and rid are ignored.
- WR_REQ: awvalid and wvalid are asserted together.
  - aw_done and w_done flags record each handshake; each valid drops after its own handshake.
  - Both handshakes may occur in the same cycle.
  - When both are done, clear the flags and go to WR_RESP.
  - awid = wid = 1, wlast = 1, wdata taken from the latch.
- wstrb is derived from size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - size 2: 1111.
- WR_RESP: bready=1. On bvalid, the source's data_ok pulses for one cycle; go to IDLE.
- Constant AXI fields: arlen = awlen = 0, burst = 2'b01, lock = 0, cache = 0, prot = 0.
- data_ok is never asserted for the channel that does not own the current transaction.
- Reset asserted mid-transaction forces IDLE and drops all valids the next edge. AXI compliance across reset is the system's responsibility: the slave is reset concurrently.
- A request held while the bridge is busy keeps its addr_ok at 0 and is granted on the first IDLE cycle.
- Throughput: a single read takes at least 3 cycles from grant to data_ok (IDLE, RD_ADDR, RD_DATA with zero-wait slave).

Optional Feature:
- Macro BRIDGE_WRITE_EARLY_ACK_EN.
- Defined: a write's data_ok pulses in the cycle the last of the AW/W handshakes completes. The FSM still waits in WR_RESP for bvalid, and the following cycle in WR_RESP gives no data_ok. The next grant still waits for IDLE.
- Undefined: write data_ok is issued only on bvalid.

Decomposition:
- Shared package (cpu_defs) gains:
  - bridge_state_t enum.
  - bridge_src_t (INST=0, DATA=1).
  - AXI id constants AXI_ID_INST=4'd0, AXI_ID_DATA=4'd1.
  - AXI_BURST_INCR=2'b01.
  - Size codes SZ_BYTE, SZ_HALF, SZ_WORD.
- One natural sub-module: bridge_wstrb_gen (size, addr[1:0] -> wstrb), reused by the core for byte-lane checks.

Test Plan:
- Inst read 0xBFC00000, slave arready=1 and rvalid next cycle with rdata 0x3C1D0010: inst_addr_ok in cycle 0, arid=0, inst_data_ok with inst_rdata=0x3C1D0010 in cycle 2.
- inst_req and data_req (read 0x80001000) asserted together: data_addr_ok=1, inst_addr_ok=0. Inst is granted on the cycle after data_data_ok, with arid=1 then arid=0.
- Byte write 0xAB to addr 0x80000003: wstrb=1000, awsize=0. Stalling wready 3 cycles keeps wvalid high while awvalid drops after its handshake. data_data_ok pulses on bvalid only.
- Half write at addr 0x80000002 with awready and wready in the same cycle: wstrb=1100, direct transition to WR_RESP.
- resetn driven low while in RD_DATA: next edge gives state IDLE, rready=0, no data_ok. A subsequent request is accepted normally.
- With BRIDGE_WRITE_EARLY_ACK_EN: word write gives data_ok on the AW/W completion cycle. A data_req issued after that gets its addr_ok only after bvalid.
